// File: rtl/radix4_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM state,
// decoded Booth flags and the 3-bit group decoder.
package radix4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_t;

    // 111 is treated as +0 rather than -0 so no stray +1 correction is added.
    function automatic booth_t booth_decode(input logic [2:0] grp);
        booth_t b;
        b.neg  = grp[2] & ~(grp[1] & grp[0]);
        b.two  = (grp == 3'b011) | (grp == 3'b100);
        b.zero = (grp == 3'b000) | (grp == 3'b111);
        return b;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product, N+2 bits. The low APPROX_COLS columns
// ignore the x2 shift in approximate mode; the bit-0 correction is left to the parent.
module booth_pp_gen
    import radix4_pkg::*;
#(
    parameter int N           = 16,
    parameter int APPROX_COLS = 6
) (
    input  logic [N-1:0] x,
    input  booth_t       bt,
    input  logic         approx_en,
    output logic [N+1:0] pp
);

    logic [N+1:0] sx;
    logic [N+1:0] sel;

    assign sx  = {{2{x[N-1]}}, x};
    assign sel = bt.two ? {sx[N:0], 1'b0} : sx;

    for (genvar t = 0; t < N + 2; t++) begin : g_col
        if (t < APPROX_COLS) begin : g_apx
            assign pp[t] = ~bt.zero & ((approx_en ? x[t] : sel[t]) ^ bt.neg);
        end else begin : g_ex
            assign pp[t] = ~bt.zero & (sel[t] ^ bt.neg);
        end
    end

endmodule

// File: rtl/radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes, PPC partial
// products per cycle and a run-time exact/approximate mode.
module radix4_seq_mult
    import radix4_pkg::*;
#(
    parameter int N           = 16,
    parameter int PPC         = 1,
    parameter int APPROX_COLS = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic           approx_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           out_approx
);

    localparam int ITER = N / (2 * PPC);
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   x_r;
    logic [N-1:0]   y_r;
    logic           ap_r;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] step_sum;
    logic [2*N-1:0] term;
    logic [N:0]     y_ext;
    logic [2*PPC:0] grp_bits;
    booth_t         bt [PPC];
    logic [N+1:0]   pp [PPC];

    // y[-1] = 0 is the appended LSB; groups overlap by one bit.
    assign y_ext    = {y_r, 1'b0};
    assign grp_bits = y_ext[2*PPC*int'(cnt) +: 2*PPC+1];

    for (genvar k = 0; k < PPC; k++) begin : g_pp
        assign bt[k] = booth_decode(grp_bits[2*k +: 3]);

        booth_pp_gen #(
            .N           (N),
            .APPROX_COLS (APPROX_COLS)
        ) u_pp (
            .x         (x_r),
            .bt        (bt[k]),
            .approx_en (ap_r),
            .pp        (pp[k])
        );
    end

    // Exact mode adds neg as a +1; approximate mode ORs it in with no carry.
    always_comb begin
        step_sum = '0;
        term     = '0;
        for (int k = 0; k < PPC; k++) begin
            term = {{(N-2){pp[k][N+1]}}, pp[k]};
            if (ap_r) begin
                term[0] = term[0] | bt[k].neg;
            end else begin
                term = term + {{(2*N-1){1'b0}}, bt[k].neg};
            end
            step_sum = step_sum + (term << (2 * k));
        end
    end

    assign acc_next = acc + (step_sum << (2 * PPC * int'(cnt)));
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            x_r        <= '0;
            y_r        <= '0;
            ap_r       <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            p          <= '0;
            out_approx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= x;
                        y_r   <= y;
                        ap_r  <= approx_en;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (cnt == CW'(ITER - 1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        p          <= acc_next;
                        out_approx <= ap_r;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            x_r   <= x;
                            y_r   <= y;
                            ap_r  <= approx_en;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_seq_mult.sv
// Bench for radix4_seq_mult: directed N=8 cases on two instances plus
// random N=16 traffic for PPC = 1, 2, 4, 8 with queued expected results.
module tb_radix4_seq_mult;

    localparam int NR = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rnd_done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for N=16, APPROX_COLS=6.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic ap);
        logic signed [31:0] sa32, sb32, prod;
        logic [31:0] accm;
        logic [17:0] sa, sel, ppm;
        logic [16:0] bb;
        logic [2:0]  g;
        logic neg, two, zero;
        if (!ap) begin
            sa32 = $signed(a);
            sb32 = $signed(b);
            prod = sa32 * sb32;
            return prod;
        end
        accm = '0;
        bb   = {b, 1'b0};
        sa   = {{2{a[15]}}, a};
        for (int i = 0; i < 8; i++) begin
            g = bb[2*i +: 3];
            neg = 1'b0; two = 1'b0; zero = 1'b0;
            case (g)
                3'b001, 3'b010: ;
                3'b011: two = 1'b1;
                3'b100: begin neg = 1'b1; two = 1'b1; end
                3'b101, 3'b110: neg = 1'b1;
                default: zero = 1'b1;
            endcase
            sel = two ? (sa << 1) : sa;
            for (int t = 0; t < 18; t++) begin
                if (zero) ppm[t] = 1'b0;
                else if (t < 6) ppm[t] = a[t] ^ neg;
                else ppm[t] = sel[t] ^ neg;
            end
            ppm[0] = ppm[0] | neg;
            accm = accm + ({{14{ppm[17]}}, ppm} << (2 * i));
        end
        return accm;
    endfunction

    // Directed instances: [0] N=8 APPROX_COLS=6, [1] N=8 APPROX_COLS=0.
    logic        d_rst [2];
    logic        d_iv  [2];
    logic        d_ir  [2];
    logic [7:0]  d_x   [2];
    logic [7:0]  d_y   [2];
    logic        d_ap  [2];
    logic        d_ov  [2];
    logic        d_or  [2];
    logic [15:0] d_p   [2];
    logic        d_oa  [2];
    logic [15:0] dq_p[$];
    logic        dq_a[$];

    radix4_seq_mult #(.N(8), .PPC(1), .APPROX_COLS(6)) u_dut_a (
        .clk(clk), .rst(d_rst[0]), .in_valid(d_iv[0]), .in_ready(d_ir[0]),
        .x(d_x[0]), .y(d_y[0]), .approx_en(d_ap[0]), .out_valid(d_ov[0]),
        .out_ready(d_or[0]), .p(d_p[0]), .out_approx(d_oa[0])
    );

    radix4_seq_mult #(.N(8), .PPC(1), .APPROX_COLS(0)) u_dut_b (
        .clk(clk), .rst(d_rst[1]), .in_valid(d_iv[1]), .in_ready(d_ir[1]),
        .x(d_x[1]), .y(d_y[1]), .approx_en(d_ap[1]), .out_valid(d_ov[1]),
        .out_ready(d_or[1]), .p(d_p[1]), .out_approx(d_oa[1])
    );

    task automatic wait_out(input int j, output int n);
        n = 0;
        while (!d_ov[j] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pop_check(input int j);
        logic [15:0] ep;
        logic        ea;
        ep = dq_p.pop_front();
        ea = dq_a.pop_front();
        check("p", d_p[j], ep);
        check("out_approx", d_oa[j], ea);
    endtask

    task automatic run_op(input int j, input logic [7:0] xa, input logic [7:0] ya,
                          input logic ap, input logic [15:0] ep, input logic eap);
        int n;
        dq_p.push_back(ep);
        dq_a.push_back(eap);
        @(posedge clk); #1;
        d_x[j] = xa; d_y[j] = ya; d_ap[j] = ap; d_iv[j] = 1'b1;
        @(negedge clk);
        check("idle_in_ready", d_ir[j], 1'b1);
        @(posedge clk); #1;
        d_iv[j] = 1'b0; d_x[j] = ~xa; d_y[j] = ~ya; d_ap[j] = ~ap;
        wait_out(j, n);
        check("latency", n, 4);
        d_or[j] = 1'b1;
        @(negedge clk);
        pop_check(j);
        @(posedge clk); #1;
        d_or[j] = 1'b0;
        check("out_valid_drop", d_ov[j], 1'b0);
    endtask

    initial begin
        int n;
        int seen;
        for (int j = 0; j < 2; j++) begin
            d_rst[j] = 1'b1; d_iv[j] = 1'b0; d_x[j] = '0; d_y[j] = '0;
            d_ap[j] = 1'b0; d_or[j] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", d_ir[0], 1'b1);
        check("rst_out_valid", d_ov[0], 1'b0);
        check("rst_p", d_p[0], 16'h0);
        check("rst_out_approx", d_oa[0], 1'b0);
        d_rst[0] = 1'b0;
        d_rst[1] = 1'b0;

        run_op(0, 8'h80, 8'h80, 1'b0, 16'h4000, 1'b0);
        run_op(0, 8'h07, 8'hFD, 1'b0, 16'hFFEB, 1'b0);
        run_op(0, 8'h0F, 8'h02, 1'b1, 16'h002D, 1'b1);
        run_op(0, 8'h0F, 8'h02, 1'b0, 16'h001E, 1'b0);
        run_op(1, 8'h02, 8'hFF, 1'b1, 16'hFFFD, 1'b1);
        run_op(1, 8'h02, 8'hFF, 1'b0, 16'hFFFE, 1'b0);

        // Sink stall, then back-to-back accept in DONE.
        dq_p.push_back(16'hFFEB);
        dq_a.push_back(1'b0);
        @(posedge clk); #1;
        d_x[0] = 8'h07; d_y[0] = 8'hFD; d_ap[0] = 1'b0; d_iv[0] = 1'b1;
        @(posedge clk); #1;
        d_iv[0] = 1'b0;
        wait_out(0, n);
        check("stall_latency", n, 4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_p", d_p[0], 16'hFFEB);
            check("stall_in_ready", d_ir[0], 1'b0);
            check("stall_out_valid", d_ov[0], 1'b1);
            @(posedge clk); #1;
        end
        d_or[0] = 1'b1;
        d_x[0] = 8'h0F; d_y[0] = 8'h02; d_ap[0] = 1'b1; d_iv[0] = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", d_ir[0], 1'b1);
        pop_check(0);
        dq_p.push_back(16'h002D);
        dq_a.push_back(1'b1);
        @(posedge clk); #1;
        d_or[0] = 1'b0; d_iv[0] = 1'b0;
        wait_out(0, n);
        check("b2b_latency", n, 4);
        d_or[0] = 1'b1;
        @(negedge clk);
        pop_check(0);
        @(posedge clk); #1;
        d_or[0] = 1'b0;

        // Reset while BUSY at cnt=2 discards the operation.
        d_x[0] = 8'h05; d_y[0] = 8'h03; d_ap[0] = 1'b0; d_iv[0] = 1'b1;
        @(posedge clk); #1;
        d_iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 d_rst[0] = 1'b1;
        #1;
        check("midrst_out_valid", d_ov[0], 1'b0);
        check("midrst_p", d_p[0], 16'h0);
        check("midrst_in_ready", d_ir[0], 1'b1);
        @(posedge clk); #1;
        d_rst[0] = 1'b0;
        d_or[0] = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (d_ov[0]) seen++;
        end
        d_or[0] = 1'b0;
        check("midrst_no_output", seen, 0);
        run_op(0, 8'h05, 8'h03, 1'b0, 16'h000F, 1'b0);

        n = 0;
        while (rnd_done_cnt < 4 && n < 60000) begin
            @(posedge clk);
            n++;
        end
        check("rnd_all_done", rnd_done_cnt, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Random N=16 traffic, one instance per PPC value.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int PPCV = 1 << gi;
        logic        rst, iv, ir, ap, ov, ordy, oa;
        logic [15:0] x, y;
        logic [31:0] p;
        logic [31:0] qp[$];
        logic        qa[$];

        radix4_seq_mult #(.N(16), .PPC(PPCV), .APPROX_COLS(6)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .x(x), .y(y), .approx_en(ap), .out_valid(ov),
            .out_ready(ordy), .p(p), .out_approx(oa)
        );

        initial begin
            int sent, got, cyc;
            logic acc_hs;
            rst = 1'b1; iv = 1'b0; ordy = 1'b0; x = '0; y = '0; ap = 1'b0;
            sent = 0; got = 0; cyc = 0; acc_hs = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            while (got < NR && cyc < NR * 20) begin
                @(posedge clk); #1;
                cyc++;
                if (acc_hs) iv = 1'b0;
                if (!iv) begin
                    x  = 16'($urandom);
                    y  = 16'($urandom);
                    ap = 1'($urandom_range(1));
                    if (sent < NR && $urandom_range(3) != 0) iv = 1'b1;
                end
                ordy = ($urandom_range(3) != 0);
                @(negedge clk);
                if (ov && ordy) begin
                    check("rnd_queue_empty", 64'(qp.size() == 0), 0);
                    if (qp.size() != 0) begin
                        check($sformatf("rnd_p_ppc%0d", PPCV), p, qp.pop_front());
                        check($sformatf("rnd_approx_ppc%0d", PPCV), oa, qa.pop_front());
                    end
                    got++;
                end
                acc_hs = iv && ir;
                if (acc_hs) begin
                    qp.push_back(model(x, y, ap));
                    qa.push_back(ap);
                    sent++;
                end
            end
            check($sformatf("rnd_count_ppc%0d", PPCV), got, NR);
            rnd_done_cnt++;
        end
    end

endmodule
